sdram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter placed between host-side masters (UART tester = port 0,

---
 rtl/sdram_port_arbiter_if.sv | 54 +++++
 rtl/sdram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of every port-side and controller-side signal of sdram_port_arbiter.
// slave  : the arbiter's view (takes requests, drives the controller command).
// master : the environment's view (requesters plus the sdram_controller).
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  // Requester port 0
  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  // Requester port 1
  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  // sdram_controller side
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_rw;
  logic              ctl_in_valid;
  logic              ctl_busy;
  logic [DATA_W-1:0] ctl_rdata;
  logic              ctl_rvalid;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wdata,
    output m0_ack, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_rw, m1_addr, m1_wdata,
    output m1_ack, m1_rvalid, m1_rdata, m1_err,
    output ctl_addr, ctl_wdata, ctl_rw, ctl_in_valid,
    input  ctl_busy, ctl_rdata, ctl_rvalid
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_wdata,
    input  m0_ack, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_rw, m1_addr, m1_wdata,
    input  m1_ack, m1_rvalid, m1_rdata, m1_err,
    input  ctl_addr, ctl_wdata, ctl_rw, ctl_in_valid,
    output ctl_busy, ctl_rdata, ctl_rvalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port round-robin arbiter in front of one sdram_controller.
// One transaction outstanding at a time. The winning command is latched into holding
// registers, presented to the controller until accepted, and read data is passed
// straight back to the owning port with no added latency.
// Optional feature: define SDRAM_ARB_WATCHDOG_EN to bound the read-return wait to
// TIMEOUT cycles; on expiry the owner gets a one-cycle err pulse.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 reset,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t            state_reg;
  logic              owner_reg;       // port that owns the current transaction
  logic              last_grant_reg;  // port whose command was accepted last
  logic              in_valid_reg;
  logic              hold_rw_reg;
  logic [ADDR_W-1:0] hold_addr_reg;
  logic [DATA_W-1:0] hold_wdata_reg;

  // Per-port views of the requester inputs so arbitration can index by port id.
  logic [1:0]        req_vec;
  logic [1:0]        rw_vec;
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];

  logic              grant;
  logic              accept;
  logic              rd_done;
  logic              rd_timeout;
  logic              wd_expired;

  logic [1:0]        ack_vec;
  logic [1:0]        rvalid_vec;
  logic [1:0]        err_vec;
  logic [DATA_W-1:0] rdata_arr [2];

  assign req_vec      = {bus.m1_req, bus.m0_req};
  assign rw_vec       = {bus.m1_rw, bus.m0_rw};
  assign addr_arr[0]  = bus.m0_addr;
  assign addr_arr[1]  = bus.m1_addr;
  assign wdata_arr[0] = bus.m0_wdata;
  assign wdata_arr[1] = bus.m1_wdata;

  // Round-robin pick: a lone requester wins, otherwise the port not granted last time.
  always_comb begin
    grant = 1'b0;
    if (req_vec == 2'b10) begin
      grant = 1'b1;
    end else if (req_vec == 2'b11) begin
      grant = ~last_grant_reg;
    end
  end

  // Handshake events. Reset masks them in the same cycle so an abort is immediate.
  assign accept     = in_valid_reg && !bus.ctl_busy && !reset;
  assign rd_done    = (state_reg == WAIT_RD) && bus.ctl_rvalid && !reset;
  assign rd_timeout = (state_reg == WAIT_RD) && wd_expired && !bus.ctl_rvalid && !reset;

`ifdef SDRAM_ARB_WATCHDOG_EN
  // Counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WD_W-1:0] wd_cnt_reg;

  assign wd_expired = (wd_cnt_reg == WD_W'(TIMEOUT));

  // Cycles spent in WAIT_RD; held at zero while the command is still being issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      wd_cnt_reg <= '0;
    end else if ((state_reg == WAIT_RD) && !wd_expired) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end
`else
  // Without the watchdog a read waits for ctl_rvalid indefinitely and err never fires.
  assign wd_expired = 1'b0;

  // TIMEOUT only matters for the watchdog build.
  if (TIMEOUT < 0) begin : g_timeout_unused
  end
`endif

  // Main FSM: arbitrate in IDLE, hold the command in ISSUE, wait for read data in WAIT_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      in_valid_reg   <= 1'b0;
      hold_rw_reg    <= 1'b0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Any ctl_rvalid seen here is stray data and is simply not forwarded.
          if (|req_vec) begin
            owner_reg      <= grant;
            hold_rw_reg    <= rw_vec[grant];
            hold_addr_reg  <= addr_arr[grant];
            hold_wdata_reg <= wdata_arr[grant];
            in_valid_reg   <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          // Requests are not looked at here; the latched command is what gets issued.
          if (!bus.ctl_busy) begin
            in_valid_reg   <= 1'b0;
            last_grant_reg <= owner_reg;
            state_reg      <= hold_rw_reg ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Data arriving on the expiry cycle still completes the read normally.
          if (bus.ctl_rvalid || wd_expired) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-port decode of the handshake events for the current owner only.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack_vec[gi]    = accept && (owner_reg == 1'(gi));
    assign rvalid_vec[gi] = rd_done && (owner_reg == 1'(gi));
    assign err_vec[gi]    = rd_timeout && (owner_reg == 1'(gi));
    assign rdata_arr[gi]  = rvalid_vec[gi] ? bus.ctl_rdata : '0;
  end

  assign bus.m0_ack    = ack_vec[0];
  assign bus.m0_rvalid = rvalid_vec[0];
  assign bus.m0_rdata  = rdata_arr[0];
  assign bus.m0_err    = err_vec[0];
  assign bus.m1_ack    = ack_vec[1];
  assign bus.m1_rvalid = rvalid_vec[1];
  assign bus.m1_rdata  = rdata_arr[1];
  assign bus.m1_err    = err_vec[1];

  assign bus.ctl_in_valid = in_valid_reg && !reset;
  assign bus.ctl_rw       = hold_rw_reg;
  assign bus.ctl_addr     = hold_addr_reg;
  assign bus.ctl_wdata    = hold_wdata_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus pushes expected port events
// (ack / rvalid / err) into a queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  localparam int K_ACK = 0;
  localparam int K_RV  = 1;
  localparam int K_ERR = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int                port;
    int                kind;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(int p, int k, logic rw, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    exp_t e;
    e.port = p; e.kind = k; e.rw = rw; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_nev, mon_p, mon_k;
  initial begin
    forever begin
      @(negedge clk);
      mon_nev = int'(bus.m0_ack) + int'(bus.m1_ack) + int'(bus.m0_rvalid) +
                int'(bus.m1_rvalid) + int'(bus.m0_err) + int'(bus.m1_err);
      if (mon_nev > 1) begin
        check("single_event_per_cycle", mon_nev, 1);
      end else if (mon_nev == 1) begin
        mon_p = (bus.m1_ack || bus.m1_rvalid || bus.m1_err) ? 1 : 0;
        mon_k = (bus.m0_ack || bus.m1_ack) ? K_ACK : ((bus.m0_rvalid || bus.m1_rvalid) ? K_RV : K_ERR);
        if (sb.size() == 0) begin
          check("unexpected_event", mon_nev, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("t=%0t event port=%0d kind=%0d (expected port=%0d kind=%0d)",
                   $time, mon_p, mon_k, mon_e.port, mon_e.kind);
          check("ev_port", mon_p, mon_e.port);
          check("ev_kind", mon_k, mon_e.kind);
          if (mon_k == K_ACK) begin
            check("ctl_rw", bus.ctl_rw, mon_e.rw);
            check("ctl_addr", bus.ctl_addr, mon_e.addr);
            if (mon_e.rw) check("ctl_wdata", bus.ctl_wdata, mon_e.data);
          end else if (mon_k == K_RV) begin
            check("rdata", mon_p ? bus.m1_rdata : bus.m0_rdata, mon_e.data);
            check("other_rdata_zero", mon_p ? bus.m0_rdata : bus.m1_rdata, 0);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input logic req, input logic rw,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_rw = rw; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_rw = rw; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic logic ack_of(int p);
    return (p == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  // Hold a request until acked (bounded), then drop req right after the ack cycle.
  task automatic drive_port(input int p, input logic rw, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int lat);
    int n;
    set_port(p, 1'b1, rw, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(p) && n < 100);
    check("ack_seen", ack_of(p), 1);
    lat = n;
    @(posedge clk); #1;
    set_port(p, 1'b0, rw, a, d);
  endtask

  // Controller model: answer each accepted read 5 cycles later with the given data.
  task automatic read_responder(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    int n;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.ctl_in_valid && !bus.ctl_busy && !bus.ctl_rw) && n < 200);
      check("read_accepted", bus.ctl_in_valid, 1);
      repeat (5) @(posedge clk);
      #1;
      bus.ctl_rvalid = 1'b1;
      bus.ctl_rdata  = (i == 0) ? d0 : d1;
      @(posedge clk); #1;
      bus.ctl_rvalid = 1'b0;
      bus.ctl_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    bus.ctl_busy = 1'b0; bus.ctl_rvalid = 1'b0; bus.ctl_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- tests ----------------
  int lat0, lat1, bad, cnt, nerr;
  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    bus.ctl_busy = 1'b0; bus.ctl_rvalid = 1'b0; bus.ctl_rdata = '0;

    // Test 1: reset state, single write from port 0
    do_reset();
    @(negedge clk);
    check("rst_in_valid", bus.ctl_in_valid, 0);
    check("rst_ctl_rw", bus.ctl_rw, 0);
    check("rst_ctl_addr", bus.ctl_addr, 0);
    check("rst_ctl_wdata", bus.ctl_wdata, 0);
    check("rst_port_outs", {bus.m0_ack, bus.m1_ack, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, 0);
    check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
    @(posedge clk); #1;
    push(0, K_ACK, 1'b1, 22'h000010, 16'hA55A);
    drive_port(0, 1'b1, 22'h000010, 16'hA55A, lat0);
    check("t1_ack_latency", lat0, 2);
    @(negedge clk);
    check("t1_in_valid_one_cycle", bus.ctl_in_valid, 0);
    drain("t1_drain");

    // Test 2: simultaneous reads, port 0 first
    do_reset();
    push(0, K_ACK, 1'b0, 22'h1, '0);
    push(0, K_RV,  1'b0, 22'h1, 16'h1111);
    push(1, K_ACK, 1'b0, 22'h2, '0);
    push(1, K_RV,  1'b0, 22'h2, 16'h2222);
    fork
      drive_port(0, 1'b0, 22'h1, '0, lat0);
      drive_port(1, 1'b0, 22'h2, '0, lat1);
      read_responder(16'h1111, 16'h2222);
    join
    check("t2_m0_latency", lat0, 2);
    drain("t2_drain");

    // Test 3: 4 back-to-back writes from each port alternate 0,1,0,1...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, K_ACK, 1'b1, ADDR_W'(32'h100 + i), DATA_W'(32'h1000 + i));
      push(1, K_ACK, 1'b1, ADDR_W'(32'h200 + i), DATA_W'(32'h2000 + i));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive_port(0, 1'b1, ADDR_W'(32'h100 + i), DATA_W'(32'h1000 + i), lat0);
      end
      begin
        for (int j = 0; j < 4; j++) drive_port(1, 1'b1, ADDR_W'(32'h200 + j), DATA_W'(32'h2000 + j), lat1);
      end
    join
    drain("t3_drain");

    // Test 4: busy held for 20 cycles in ISSUE; ack on first non-busy cycle
    do_reset();
    bus.ctl_busy = 1'b1;
    push(0, K_ACK, 1'b1, 22'h3FFFFF, 16'hFFFF);
    fork
      drive_port(0, 1'b1, 22'h3FFFFF, 16'hFFFF, lat0);
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!bus.ctl_in_valid && cnt < 50);
        check("t4_in_valid_rise", bus.ctl_in_valid, 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          if (k > 0) @(negedge clk);
          if (!bus.ctl_in_valid || bus.m0_ack || bus.ctl_addr != 22'h3FFFFF ||
              !bus.ctl_rw || bus.ctl_wdata != 16'hFFFF) bad++;
        end
        check("t4_busy_hold_bad_cycles", bad, 0);
        @(posedge clk); #1;
        bus.ctl_busy = 1'b0;
        @(negedge clk);
        check("t4_ack_first_free_cycle", bus.m0_ack, 1);
      end
    join
    drain("t4_drain");

    // Test 5: reset while waiting for read data; data afterwards is dropped
    do_reset();
    push(1, K_ACK, 1'b0, 22'h5, '0);
    drive_port(1, 1'b0, 22'h5, '0, lat1);
    reset = 1'b1;
    bus.ctl_rvalid = 1'b1; bus.ctl_rdata = 16'hDEAD;
    @(negedge clk);
    check("t5_rvalid_masked_in_reset", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    @(posedge clk); #1;
    bus.ctl_rvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.ctl_rvalid = 1'b1;
    @(negedge clk);
    check("t5_stray_rvalid_dropped", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    check("t5_idle_no_in_valid", bus.ctl_in_valid, 0);
    @(posedge clk); #1;
    bus.ctl_rvalid = 1'b0; bus.ctl_rdata = '0;
    push(0, K_ACK, 1'b1, 22'h6, 16'h0606);
    drive_port(0, 1'b1, 22'h6, 16'h0606, lat0);
    check("t5_idle_after_reset_latency", lat0, 2);
    drain("t5_drain");

    // Test 6: read that never returns
    do_reset();
    push(1, K_ACK, 1'b0, 22'h7, '0);
`ifdef SDRAM_ARB_WATCHDOG_EN
    push(1, K_ERR, 1'b0, 22'h7, '0);
    push(0, K_ACK, 1'b1, 22'h8, 16'h0808);
    fork
      begin
        drive_port(1, 1'b0, 22'h7, '0, lat1);
        nerr = 0;
        do begin
          @(negedge clk);
          nerr++;
        end while (!bus.m1_err && nerr < 100);
        check("t6_err_delay", nerr, TIMEOUT + 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_port(0, 1'b1, 22'h8, 16'h0808, lat0);
      end
    join
`else
    push(1, K_RV, 1'b0, 22'h7, 16'hBEEF);
    push(0, K_ACK, 1'b1, 22'h8, 16'h0808);
    fork
      begin
        drive_port(1, 1'b0, 22'h7, '0, lat1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (bus.m0_ack || bus.m1_rvalid || bus.m0_err || bus.m1_err) cnt++;
        end
        check("t6_still_waiting_events", cnt, 0);
        @(posedge clk); #1;
        bus.ctl_rvalid = 1'b1; bus.ctl_rdata = 16'hBEEF;
        @(posedge clk); #1;
        bus.ctl_rvalid = 1'b0; bus.ctl_rdata = '0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_port(0, 1'b1, 22'h8, 16'h0808, lat0);
      end
    join
`endif
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
